// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
//   Each MULT/MULTU/DIV/DIVU takes 32 iteration cycles. Then the result is
//   committed and `done` pulses for one cycle.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   start  : request a new operation (accepted in IDLE or DONE)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   inRD1  : rs operand (multiplicand / dividend / MTHI-MTLO data)
//   inRD2  : rt operand (multiplier / divisor)
//   wrHi   : MTHI write enable (ignored while iterating)
//   wrLo   : MTLO write enable (ignored while iterating)
//   outHi  : HI register
//   outLo  : LO register
//   busy   : high while iterating
//   done   : one-cycle pulse when a result has just been committed
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] inRD1,
  input  logic [31:0] inRD2,
  input  logic        wrHi,
  input  logic        wrLo,
  output logic [31:0] outHi,
  output logic [31:0] outLo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [1:0]  op_q, op_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        div0_q, div0_d;
  logic [31:0] opnd_q, opnd_d;   // multiplicand (mul) or divisor (div), absolute value
  logic [63:0] acc_q, acc_d;     // {partial product, multiplier} or {remainder, dividend/quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand preparation for a new operation
  logic        in_signed;
  logic [31:0] abs_a, abs_b;

  // Iteration datapath
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [64:0] div_shift;
  logic [32:0] div_trial;
  logic        div_ge;
  logic [63:0] div_next;
  logic [63:0] iter_next;

  // Final fix-up
  logic        run_signed;
  logic        neg_res;
  logic [63:0] mul_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  always_comb begin
    in_signed = ~op[0];
    // Plain 32-bit negation, so |0x80000000| stays 0x80000000 and is
    // treated as the unsigned magnitude 2^31.
    abs_a = (in_signed && inRD1[31]) ? (32'd0 - inRD1) : inRD1;
    abs_b = (in_signed && inRD2[31]) ? (32'd0 - inRD2) : inRD2;

    // Shift-add multiply: add multiplicand to the upper half when the
    // current multiplier LSB is set, then shift the whole 65-bit value right.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};

    // Restoring divide: shift {rem, dividend} left, try subtracting the
    // divisor from the 33-bit partial remainder, keep it if non-negative.
    div_shift = {acc_q, 1'b0};
    div_trial = div_shift[64:32] - {1'b0, opnd_q};
    div_ge    = ~div_trial[32];
    div_next  = {(div_ge ? div_trial[31:0] : div_shift[63:32]), div_shift[31:1], div_ge};

    iter_next = op_q[1] ? div_next : mul_next;

    run_signed = ~op_q[0];
    neg_res    = run_signed && (sign_a_q ^ sign_b_q);
    mul_fix    = neg_res ? (64'd0 - iter_next) : iter_next;
    // A zero divisor naturally yields an all-ones quotient and a remainder
    // equal to |dividend|; the remainder sign fix restores the original
    // inRD1, and the quotient is forced so the sign fix cannot disturb it.
    quo_fix    = div0_q ? 32'hFFFF_FFFF
               : (neg_res ? (32'd0 - iter_next[31:0]) : iter_next[31:0]);
    rem_fix    = (run_signed && sign_a_q) ? (32'd0 - iter_next[63:32]) : iter_next[63:32];

    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_RUN: begin
        acc_d   = iter_next;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = mul_fix[63:32];
            lo_d = mul_fix[31:0];
          end
          state_d = S_DONE;
        end
      end
      default: begin
        // IDLE and DONE behave identically: register writes are honoured
        // even when a start is accepted in the same cycle.
        if (wrHi) hi_d = inRD1;
        if (wrLo) lo_d = inRD1;
        if (start) begin
          op_d     = op;
          sign_a_d = inRD1[31];
          sign_b_d = inRD2[31];
          div0_d   = (inRD2 == 32'd0);
          count_d  = 5'd0;
          if (op[1]) begin
            opnd_d = abs_b;
            acc_d  = {32'd0, abs_a};
          end else begin
            opnd_d = abs_a;
            acc_d  = {32'd0, abs_b};
          end
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      op_q     <= 2'd0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign outHi = hi_q;
  assign outLo = lo_q;
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Table-driven vectors plus random vectors through a scoreboard queue,
//   and hand-written sequences for mid-run start/write, write-with-start
//   and reset during RUN.
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in_rd1;
  logic [31:0] in_rd2;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        busy;
  logic        done;

  mult_div_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .inRD1 (in_rd1),
    .inRD2 (in_rd2),
    .wrHi  (wr_hi),
    .wrLo  (wr_lo),
    .outHi (out_hi),
    .outLo (out_lo),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        sb_q[$];
  int          total;
  int          bad;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    longint      sa, sb, p;
    logic [63:0] u;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    r.hi = 32'd0;
    r.lo = 32'd0;
    case (o)
      2'd0: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'd1: begin u = {32'd0, a} * {32'd0, b}; r.hi = u[63:32]; r.lo = u[31:0]; end
      2'd2: begin r.lo = ia / ib; r.hi = ia % ib; end
      default: begin r.lo = a / b; r.hi = a % b; end
    endcase
    return r;
  endfunction

  // Called just after a falling edge; the start is sampled at the next rising edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] ehi, input logic [31:0] elo);
    res_t r;
    op     = o;
    in_rd1 = a;
    in_rd2 = b;
    start  = 1'b1;
    if (push) begin
      r.hi = ehi;
      r.lo = elo;
      sb_q.push_back(r);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
  endtask

  // Watches one operation; returns at the falling edge inside the DONE cycle.
  // inject_at > 0 pulses an ignored start + MTHI at that RUN cycle.
  task automatic wait_result(input string name, input int inject_at);
    int   busy_cnt;
    int   k;
    bit   got;
    bit   overlap;
    bit   held_bad;
    res_t e;
    busy_cnt = 0;
    got      = 0;
    overlap  = 0;
    held_bad = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1;
      if (busy && (out_hi !== m_hi || out_lo !== m_lo)) held_bad = 1;
      if (k == inject_at) begin
        start  = 1'b1;
        op     = 2'd3;
        in_rd1 = 32'h1234;
        wr_hi  = 1'b1;
      end
      if (inject_at > 0 && k == inject_at + 1) begin
        start = 1'b0;
        wr_hi = 1'b0;
      end
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({name, " latency"}, 64'(k), 64'd33);
    chk({name, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    chk({name, " busy_done_overlap"}, {63'd0, overlap}, 64'd0);
    chk({name, " hilo_held_in_run"}, {63'd0, held_bad}, 64'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (got) begin
        chk({name, " hi"}, {32'd0, out_hi}, {32'd0, e.hi});
        chk({name, " lo"}, {32'd0, out_lo}, {32'd0, e.lo});
      end
      m_hi = e.hi;
      m_lo = e.lo;
    end
  endtask

  vec_t vecs[12];

  initial begin
    vec_t v;
    res_t r;
    bit   done_seen;

    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'd0;
    in_rd1 = 32'd0;
    in_rd2 = 32'd0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;

    vecs[0]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'd2, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
    vecs[6]  = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
    vecs[9]  = '{2'd3, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 32'h0FFF_FFFF};
    vecs[10] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[11] = '{2'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset hi", {32'd0, out_hi}, 64'd0);
    chk("reset lo", {32'd0, out_lo}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    // MTHI + MTLO together in IDLE
    @(negedge clk);
    in_rd1 = 32'hDEAD_BEEF;
    wr_hi  = 1'b1;
    wr_lo  = 1'b1;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    @(negedge clk);
    chk("idle_wr hi", {32'd0, out_hi}, 64'hDEAD_BEEF);
    chk("idle_wr lo", {32'd0, out_lo}, 64'hDEAD_BEEF);
    chk("idle_wr busy", {63'd0, busy}, 64'd0);
    chk("idle_wr done", {63'd0, done}, 64'd0);
    m_hi = 32'hDEAD_BEEF;
    m_lo = 32'hDEAD_BEEF;

    // Table vectors, each started in the previous DONE cycle (back-to-back)
    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      launch(v.op, v.a, v.b, 1'b1, v.hi, v.lo);
      wait_result($sformatf("vec%0d op%0d %h,%h", i, v.op, v.a, v.b), 0);
    end
    @(negedge clk);
    chk("done_single_cycle", {63'd0, done}, 64'd0);

    // Random vectors through the model, also back-to-back
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (ro[1] && rb == 32'd0) rb = 32'd3;
      if (ro == 2'd2 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) ra = 32'd1;
      r = model(ro, ra, rb);
      launch(ro, ra, rb, 1'b1, r.hi, r.lo);
      wait_result($sformatf("rnd%0d op%0d %h,%h", i, ro, ra, rb), 0);
    end

    // Start and MTHI in RUN are ignored
    @(negedge clk);
    launch(2'd1, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);
    wait_result("ignore_in_run", 5);

    // MTHI/MTLO in the same cycle as an accepted start take effect first
    @(negedge clk);
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    launch(2'd1, 32'h0000_00AB, 32'd2, 1'b1, 32'd0, 32'h0000_0156);
    m_hi = 32'h0000_00AB;
    m_lo = 32'h0000_00AB;
    wait_result("wr_with_start", 0);

    // Reset in RUN cycle 10
    @(negedge clk);
    launch(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0, 32'd0);
    for (int k = 1; k <= 10; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst hi", {32'd0, out_hi}, 64'd0);
    chk("mid_rst lo", {32'd0, out_lo}, 64'd0);
    chk("mid_rst busy", {63'd0, busy}, 64'd0);
    rst  = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1;
    end
    chk("mid_rst no_done", {63'd0, done_seen}, 64'd0);
    launch(2'd1, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
    wait_result("after_rst multu 2x3", 0);

    @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
